// File: rtl/adc_conv_arbiter.sv
// Round-robin arbiter sharing one SAR ADC conversion engine among NREQ requesters.
// It drives the core's start-of-conversion and channel select, enforces a SoC-low gap and a conversion timeout.
module adc_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 10,
    parameter int TW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_ch,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     rdata,
    output logic [2:0]        rch,
    output logic              adc_soc,
    output logic [2:0]        adc_ch_sel,
    input  logic              adc_eoc,
    input  logic [DW-1:0]     adc_data,
    input  logic [7:0]        min_gap,
    input  logic [TW-1:0]     timeout,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              err,
    output logic [IDW-1:0]    err_id
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic            eoc_q;
    logic            eoc_rise;
    logic [TW-1:0]   tcnt;
    logic [7:0]      gcnt;
    logic            timed_out;
    logic            grant;

    logic [2:0]      ch_arr [NREQ];
    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  idx;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] gid_oh;

    assign eoc_rise  = adc_eoc & ~eoc_q;
    assign timed_out = (timeout != '0) && (tcnt == timeout);
    assign grant     = (state == S_IDLE) && en && pick_found;

    // Search starts one past the last winner, so the last winner has lowest priority.
    // NOTE: every variable gets a default at the top of always_comb, otherwise a latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = grant_id;
        idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            ch_arr[i] = req_ch[3*i +: 3];
        end
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(grant_id) + k) % NREQ);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_comb begin
        pick_oh          = '0;
        pick_oh[pick_id] = 1'b1;
        gid_oh           = '0;
        gid_oh[grant_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant) state_nxt = S_CONV;
            S_CONV: begin
                // A rising eoc in the same cycle as the timeout still counts as a good result.
                if (eoc_rise)       state_nxt = S_DONE;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_DONE,
            S_ERR:  state_nxt = S_GAP;
            S_GAP:  if (gcnt == 8'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            eoc_q      <= 1'b0;
            tcnt       <= '0;
            gcnt       <= '0;
            ack        <= '0;
            done       <= '0;
            err        <= 1'b0;
            err_id     <= '0;
            rdata      <= '0;
            rch        <= '0;
            adc_soc    <= 1'b0;
            adc_ch_sel <= '0;
            grant_id   <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            eoc_q <= adc_eoc;
            ack   <= '0;
            done  <= '0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        grant_id   <= pick_id;
                        adc_ch_sel <= ch_arr[pick_id];
                        ack        <= pick_oh;
                        adc_soc    <= 1'b1;
                        tcnt       <= '0;
                    end
                end
                S_CONV: begin
                    if (eoc_rise) begin
                        rdata   <= adc_data;
                        rch     <= adc_ch_sel;
                        done    <= gid_oh;
                        adc_soc <= 1'b0;
                    end else if (timed_out) begin
                        err     <= 1'b1;
                        err_id  <= grant_id;
                        adc_soc <= 1'b0;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DONE,
                S_ERR: gcnt <= min_gap;
                S_GAP: if (gcnt != 8'd0) gcnt <= gcnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Scoreboard bench for adc_conv_arbiter: a stimulus process predicts grants and results,
// a monitor process compares them whenever the arbiter pulses ack, done or err.
`timescale 1ns/1ps
module tb_adc_conv_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 10;
    localparam int TW   = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_ch;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     rdata;
    logic [2:0]        rch;
    logic              adc_soc;
    logic [2:0]        adc_ch_sel;
    logic              adc_eoc;
    logic [DW-1:0]     adc_data;
    logic [7:0]        min_gap;
    logic [TW-1:0]     timeout;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              err;
    logic [IDW-1:0]    err_id;

    logic [2:0] ch_tb [NREQ];

    adc_conv_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .TW(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_ch(req_ch),
        .ack(ack), .done(done), .rdata(rdata), .rch(rch),
        .adc_soc(adc_soc), .adc_ch_sel(adc_ch_sel), .adc_eoc(adc_eoc), .adc_data(adc_data),
        .min_gap(min_gap), .timeout(timeout), .busy(busy), .grant_id(grant_id),
        .err(err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_ch = '0;
        for (int i = 0; i < NREQ; i++) req_ch[3*i +: 3] = ch_tb[i];
    end

    typedef struct { int id; logic [2:0] ch; } ack_exp_t;
    typedef struct { bit is_err; int id; logic [2:0] ch; logic [DW-1:0] data; } res_exp_t;

    ack_exp_t ack_q[$];
    ack_exp_t stim_q[$];
    res_exp_t res_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_count = 0, end_count = 0, ack_cyc = 0, end_cyc = 0;
    int acks_waited = 0, ends_waited = 0;
    int last_gid;
    bit gap_check_en = 1'b0;
    bit had_soc = 1'b0;
    int low_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                ack_count++;
                ack_cyc = cyc;
                if (ack_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack: got ack=%b, expected none (cycle %0d)", ack, cyc);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    check("ack_onehot", 32'(ack), 32'(1) << e.id);
                    check("ack_grant_id", 32'(grant_id), 32'(e.id));
                    check("ack_ch_sel", 32'(adc_ch_sel), 32'(e.ch));
                    check("ack_soc_high", 32'(adc_soc), 32'd1);
                    check("ack_busy", 32'(busy), 32'd1);
                end
            end
            if (done !== '0 || err !== 1'b0) begin
                end_count++;
                end_cyc = cyc;
                if (res_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result: got done=%b err=%b, expected none (cycle %0d)", done, err, cyc);
                end else begin
                    res_exp_t r;
                    r = res_q.pop_front();
                    check("result_soc_low", 32'(adc_soc), 32'd0);
                    if (r.is_err) begin
                        check("err_pulse", 32'(err), 32'd1);
                        check("err_no_done", 32'(done), 32'd0);
                        check("err_id", 32'(err_id), 32'(r.id));
                    end else begin
                        check("done_onehot", 32'(done), 32'(1) << r.id);
                        check("done_no_err", 32'(err), 32'd0);
                        check("rdata", 32'(rdata), 32'(r.data));
                        check("rch", 32'(rch), 32'(r.ch));
                    end
                end
            end
            if (!gap_check_en) begin
                had_soc = 1'b0;
                low_run = 0;
            end else if (adc_soc === 1'b0) begin
                low_run++;
            end else begin
                if (had_soc && low_run > 0) check("soc_low_gap", 32'(low_run), 32'(min_gap) + 32'd3);
                had_soc = 1'b1;
                low_run = 0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Reference arbitration: the next winner is the first pending requester after the last one served.
    task automatic predict();
        int w;
        ack_exp_t e;
        w = rr_pick(last_gid, req);
        if (w < 0 || !en) return;
        e.id = w;
        e.ch = ch_tb[w];
        ack_q.push_back(e);
        stim_q.push_back(e);
        last_gid = w;
    endtask

    task automatic add_random_requests();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i]   = 1'b1;
                ch_tb[i] = 3'($urandom_range(0, 7));
            end
        end
        if (req == '0) begin
            int j;
            j = $urandom_range(0, NREQ - 1);
            req[j]   = 1'b1;
            ch_tb[j] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (ack_count <= acks_waited && n < budget) begin
            tick();
            n++;
        end
        check("ack_arrived", 32'(ack_count > acks_waited), 32'd1);
        acks_waited = ack_count;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (end_count <= ends_waited && n < budget) begin
            tick();
            n++;
        end
        check("result_arrived", 32'(end_count > ends_waited), 32'd1);
        ends_waited = end_count;
    endtask

    task automatic txn(input bit drop_req, input bit add_new, input bit stop, input bit drop_en,
                       input bit raise_eoc, input int lat, input int hold, input logic [DW-1:0] data);
        ack_exp_t cur;
        res_exp_t r;
        cur = stim_q.pop_front();
        wait_ack(400);
        if (drop_en) en = 1'b0;
        if (drop_req) req[cur.id] = 1'b0;
        if (add_new) add_random_requests();
        if (stop) req = '0;
        else predict();
        while (cyc < ack_cyc + lat) tick();
        r.id = cur.id;
        r.ch = cur.ch;
        if (raise_eoc) begin
            adc_data = data;
            adc_eoc  = 1'b1;
            r.is_err = 1'b0;
            r.data   = data;
            res_q.push_back(r);
            repeat (hold) tick();
            adc_eoc = 1'b0;
        end else begin
            r.is_err = 1'b1;
            r.data   = '0;
            res_q.push_back(r);
        end
        wait_end(int'(timeout) + lat + hold + 100);
        tick();
    endtask

    initial begin
        int c0;
        rst = 1'b1; en = 1'b0; req = '0; adc_eoc = 1'b0; adc_data = '0;
        min_gap = '0; timeout = '0; last_gid = NREQ - 1;
        for (int i = 0; i < NREQ; i++) ch_tb[i] = '0;
        repeat (3) tick();

        check("rst_ack", 32'(ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rch", 32'(rch), 32'd0);
        check("rst_soc", 32'(adc_soc), 32'd0);
        check("rst_ch_sel", 32'(adc_ch_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_id", 32'(err_id), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'(NREQ - 1));
        rst = 1'b0;
        tick();

        // Single request on channel 5, eoc 40 cycles after soc.
        min_gap = 8'd2; timeout = '0; en = 1'b1;
        ch_tb[0] = 3'd5; req = 4'b0001;
        predict();
        c0 = cyc;
        txn(1, 0, 1, 0, 1, 40, 3, 10'h2A5);
        check("single_ack_latency", 32'(ack_cyc - c0), 32'd1);
        check("single_done_latency", 32'(end_cyc - ack_cyc), 32'd41);
        repeat (20) tick();

        // Fairness with all requests held, and exact SoC-low gap.
        min_gap = 8'd6;
        for (int i = 0; i < NREQ; i++) ch_tb[i] = 3'(i);
        req = 4'b1111;
        gap_check_en = 1'b1;
        predict();
        for (int n = 0; n < 8; n++)
            txn(0, 0, n == 7, 0, 1, $urandom_range(3, 20), $urandom_range(1, 5), DW'($urandom));
        gap_check_en = 1'b0;
        repeat (20) tick();

        // Timeout of 100 cycles, then the next grant proceeds.
        timeout = 12'd100; min_gap = 8'd3;
        ch_tb[2] = 3'd3; req = 4'b0100;
        predict();
        txn(1, 0, 1, 0, 0, 0, 0, '0);
        check("timeout_latency", 32'(end_cyc - ack_cyc), 32'd101);
        ch_tb[1] = 3'd6; req = 4'b0010;
        predict();
        txn(1, 0, 1, 0, 1, 10, 2, 10'h155);
        check("err_id_holds", 32'(err_id), 32'd2);
        repeat (20) tick();

        // Eoc rise lands on the timeout cycle and stays high 20 cycles.
        timeout = 12'd30;
        ch_tb[0] = 3'd7; req = 4'b0001;
        predict();
        txn(1, 0, 1, 0, 1, 30, 20, 10'h3C3);
        check("coincide_done_latency", 32'(end_cyc - ack_cyc), 32'd31);
        repeat (20) tick();

        // Timeout disabled: a 300-cycle conversion completes normally.
        timeout = '0;
        ch_tb[3] = 3'd2; req = 4'b1000;
        predict();
        txn(1, 0, 1, 0, 1, 300, 2, 10'h0F1);
        check("no_timeout_latency", 32'(end_cyc - ack_cyc), 32'd301);
        repeat (20) tick();

        // Enable dropped mid-conversion: finishes, then no grants until re-enabled.
        ch_tb[0] = 3'd1; ch_tb[1] = 3'd4; req = 4'b0011;
        predict();
        txn(0, 0, 0, 1, 1, 10, 2, 10'h2D2);
        repeat (40) tick();
        check("no_grant_while_disabled", 32'(ack_count - acks_waited), 32'd0);
        en = 1'b1;
        predict();
        txn(1, 0, 1, 0, 1, 8, 2, 10'h111);
        repeat (20) tick();

        // Randomized back-to-back traffic with occasional timeouts.
        timeout = 12'd80;
        min_gap = 8'($urandom_range(0, 5));
        req = '0;
        add_random_requests();
        gap_check_en = 1'b1;
        predict();
        for (int n = 0; n < 40; n++)
            txn(1, 1, n == 39, 0, $urandom_range(0, 5) != 0, $urandom_range(1, 40),
                $urandom_range(1, 8), DW'($urandom));
        gap_check_en = 1'b0;
        repeat (20) tick();

        // Reset mid-conversion aborts without done or err.
        ch_tb[2] = 3'd5; req = 4'b0100;
        predict();
        void'(stim_q.pop_front());
        wait_ack(100);
        req = '0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_soc", 32'(adc_soc), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'(NREQ - 1));
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        last_gid = NREQ - 1;
        adc_eoc = 1'b1;
        repeat (3) tick();
        adc_eoc = 1'b0;
        repeat (20) tick();
        check("midrst_no_result", 32'(end_count - ends_waited), 32'd0);

        // After reset requester 0 has first priority again.
        ch_tb[0] = 3'd3; ch_tb[1] = 3'd6; req = 4'b0011;
        predict();
        txn(1, 0, 1, 0, 1, 12, 2, 10'h0AA);
        repeat (10) tick();

        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
